ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibits the bus, issues a request-to-send,
// shifts out data/parity/stop on device clock edges and checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2k_clk,
  input  logic       ps2k_data,
  output logic       ps2k_clk_oe,
  output logic       ps2k_data_oe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy
);

  localparam int MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;

  state_t           state, state_n;
  logic             clk_r0, clk_r1, clk_r2;
  logic             data_r0, data_r1, data_r2;
  logic [7:0]       byte_q, byte_n;
  logic             par_q, par_n;
  logic [3:0]       bit_cnt, bit_n;
  logic             doe_q, doe_n;
  logic             done_q, done_n;
  logic             err_q, err_n;
  logic [CNT_W-1:0] cnt;
  logic             fall, to_hit, counting_st, tracking_st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_r0  <= 1'b1;
      clk_r1  <= 1'b1;
      clk_r2  <= 1'b1;
      data_r0 <= 1'b1;
      data_r1 <= 1'b1;
      data_r2 <= 1'b1;
    end else begin
      clk_r0  <= ps2k_clk;
      clk_r1  <= clk_r0;
      clk_r2  <= clk_r1;
      data_r0 <= ps2k_data;
      data_r1 <= data_r0;
      data_r2 <= data_r1;
    end
  end

  assign fall        = ~clk_r1 & clk_r2;
  assign counting_st = (state == INHIBIT) || (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
  assign tracking_st = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
  assign to_hit      = tracking_st && (cnt == TO_LAST) && !fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      byte_q  <= '0;
      par_q   <= 1'b0;
      bit_cnt <= '0;
      doe_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      byte_q  <= byte_n;
      par_q   <= par_n;
      bit_cnt <= bit_n;
      doe_q   <= doe_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  // Shared inhibit / inactivity counter: restarts on every state change and device edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if ((state_n != state) || (fall && tracking_st))
      cnt <= '0;
    else if (counting_st)
      cnt <= cnt + 1'b1;
  end

  always_comb begin
    state_n = state;
    byte_n  = byte_q;
    par_n   = par_q;
    bit_n   = bit_cnt;
    doe_n   = doe_q;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        doe_n = 1'b0;
        if (tx_valid) begin
          byte_n  = tx_data;
          par_n   = ~^tx_data;
          bit_n   = '0;
          doe_n   = 1'b1;
          state_n = INHIBIT;
        end
      end
      INHIBIT: if (cnt == INH_LAST) state_n = REQ;
      REQ:     state_n = SEND;
      SEND: begin
        if (fall) begin
          bit_n = 4'(bit_cnt + 4'd1);
          if (bit_cnt < 4'd8)       doe_n = ~byte_q[bit_cnt[2:0]];
          else if (bit_cnt == 4'd8) doe_n = ~par_q;
          else                      doe_n = 1'b0;
          if (bit_cnt == 4'd9) state_n = ACK;
        end else if (to_hit) begin
          doe_n   = 1'b0;
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      ACK: begin
        if (fall) begin
          bit_n = 4'(bit_cnt + 4'd1);
          if (data_r1) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = WAIT_IDLE;
          end
        end else if (to_hit) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_r1 && data_r1) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (to_hit) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign ps2k_clk_oe  = (state == INHIBIT) || (state == REQ);
  assign ps2k_data_oe = (state == REQ) || ((state == SEND) && doe_q);
  assign tx_ready     = (state == IDLE);
  assign busy         = (state != IDLE);
  assign tx_done      = done_q;
  assign tx_err       = err_q;

endmodule
